axi_lite_bram_strb: RTL and testbench
=====================================

Name: axi_lite_bram_strb

Overview:
- Parametrised AXI4-Lite slave wrapping an on-chip block-RAM array; successor to the fixed 16-bit-address / 32-bit-data BRAM slave.
- Adds byte-lane write strobes, configurable data width and depth, independent AW/W acceptance, concurrent read and write channels, and SLVERR for out-of-range addresses.
- Sits behind the AXI4-Lite interconnect as a scratchpad or register-file memory.

Parameters:
- ADDR_WIDTH, 16, byte-address width of AW/AR.
- DATA_WIDTH, 32, data bus width; legal values 32 or 64.
- DEPTH, 1024, number of DATA_WIDTH words; power of two; DEPTH*(DATA_WIDTH/8) must not exceed 2**ADDR_WIDTH.

Ports:
- s_aclk  in  1  clock; all logic is rising-edge.
- s_aresetn  in  1  synchronous, active-low reset.
- s_axi_awvalid  in  1  write-address valid.
- s_axi_awready  out  1  write-address ready.
- s_axi_awaddr  in  ADDR_WIDTH  write byte address.
- s_axi_wvalid  in  1  write-data valid.
- s_axi_wready  out  1  write-data ready.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  DATA_WIDTH/8  byte-lane enables.
- s_axi_bvalid  out  1  write-response valid.
- s_axi_bready  in  1  write-response ready.
- s_axi_bresp  out  2  write response: OKAY 2'b00 or SLVERR 2'b10.
- s_axi_arvalid  in  1  read-address valid.
- s_axi_arready  out  1  read-address ready.
- s_axi_araddr  in  ADDR_WIDTH  read byte address.
- s_axi_rvalid  out  1  read-data valid.
- s_axi_rready  in  1  read-data ready.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response: OKAY or SLVERR.

Behaviour:
- Reset: s_aresetn=0 at a rising edge applies the synchronous, active-low reset.
  - Cleared: all ready/valid outputs, bresp, rresp, rdata, captured address/data/strb holding registers; both FSMs return to IDLE.
  - Memory contents are not cleared.
  - Reset mid-transaction abandons the transaction; no partial write is committed.
- Addressing:
  - Word index = addr >> log2(DATA_WIDTH/8); low byte-offset bits are ignored.
  - An index >= DEPTH is out of range.
- Write FSM, WR_IDLE:
  - awready = !aw_held; wready = !w_held.
  - AW and W handshakes may occur in either order or in the same cycle.
  - Each handshake latches its payload and sets its held flag.
- Write commit: on the first edge where both held flags are set, the FSM moves to WR_RESP.
  - In range: for each lane i with wstrb[i]=1, the byte is written; other lanes keep their old value. bresp=OKAY.
  - Out of range: no write occurs. bresp=SLVERR.
  - bvalid rises on the same edge as the commit, so the response appears 1 cycle after the later of the two handshakes.
- WR_RESP:
  - awready=wready=0; bvalid and bresp are held stable until bready=1.
  - On the bvalid&&bready edge: clear the held flags, bvalid←0, return to WR_IDLE.
- Read FSM, RD_IDLE: arready=1. On the arvalid handshake, read the array registered and move to RD_DATA.
  - rvalid=1 on the next edge: 1-cycle latency.
  - Out of range: rdata=0, rresp=SLVERR.
- RD_DATA:
  - arready=0; rdata and rresp are held stable until rready=1, then rvalid←0 and return to RD_IDLE.
  - No back-to-back reads: minimum 2 cycles per read.
- Read and write channels run concurrently.
  - If a write commits on the same edge as an AR handshake to the same word, the read returns the pre-write data (read-first).
- wstrb=0 with an in-range address: no bytes change; bresp=OKAY.
- Holding inputs asserted after a handshake has no effect until the FSM is back in IDLE.

Decomposition:
- Shared package axi_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, wr_state_t {WR_IDLE, WR_RESP}, rd_state_t {RD_IDLE, RD_DATA}.
- Sub-module bram_be_sdp (simple dual-port RAM with byte enables: one write port, one registered read port, parameters DATA_WIDTH and DEPTH).
  - Keeps the AXI FSMs separate from the array so synthesis infers BRAM.

Test Plan:
- Aligned write and readback: AW 0x0004 and W 0x0000000A, wstrb 4'hF, issued together → bvalid 1 cycle later with OKAY; AR 0x0004 → rvalid next cycle, rdata 0x0000000A, rresp OKAY.
- W before AW: W 0x110A0FB9 two cycles before AW 0x0A0C → no bvalid until AW arrives, bvalid 1 cycle after it; readback gives 0x110A0FB9.
- Byte strobes: word 0x0010 preloaded 0xFFFFFFFF, write 0x12345678 with wstrb 4'b0101 → readback 0xFF34FF78.
- Out of range (DEPTH=1024, DATA_WIDTH=32): write to 0x1000 → bresp SLVERR and no array change; read from 0x1000 → rdata 0, rresp SLVERR.
- Backpressure: hold bready=0 and rready=0 for 5 cycles → bvalid/rvalid, bresp/rresp and rdata stay stable; awready=wready=arready=0 throughout.
- Reset mid-op: assert s_aresetn=0 after the AW handshake but before W → all outputs 0 after the edge; a later read of that address returns the old contents.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the write/read channel state types.
// The debug struct packs both channel states so checkers can bind to one signal.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  typedef struct packed {
    wr_state_t wr;
    rd_state_t rd;
  } fsm_dbg_t;

endpackage

// File: rtl/bram_be_sdp.sv
// Simple dual-port RAM: one byte-enabled write port and one registered read port.
// Read and write share a clock; a same-address collision returns the old word (read-first).
module bram_be_sdp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [$clog2(DEPTH)-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [DATA_WIDTH/8-1:0]     wbe,
  input  logic                        re,
  input  logic [$clog2(DEPTH)-1:0]    raddr,
  output logic [DATA_WIDTH-1:0]       rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we && wbe[i]) begin
        mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // No reset on the output register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_lite_bram_strb.sv
// AXI4-Lite slave in front of a byte-enabled block RAM, with independent AW/W capture,
// concurrent read/write channels and SLVERR for word indices beyond DEPTH.
//
// Handshake rule on every channel: a transfer happens on the rising edge where
// valid && ready are both 1; a raised valid keeps its payload stable until that edge,
// and ready may depend on state but never on the same-cycle valid.
module axi_lite_bram_strb
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                      s_aclk,
  input  logic                      s_aresetn,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  output logic [1:0]                s_axi_bresp,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output fsm_dbg_t                  dbg_fsm
);

  localparam int NB      = DATA_WIDTH / 8;
  localparam int OFFS    = $clog2(NB);
  localparam int RAM_AW  = $clog2(DEPTH);
  localparam int IDX_TOP = OFFS + RAM_AW;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                  ready_en;
  logic                  aw_held, w_held;
  logic [RAM_AW-1:0]     aw_idx_q;
  logic                  aw_oor_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NB-1:0]         w_strb_q;
  logic [1:0]            bresp_q;
  logic                  rd_err_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic commit, ram_we;
  logic aw_oor, ar_oor;
  logic [DATA_WIDTH-1:0] ram_q;

  // Byte-offset bits never select anything: they only exist on the bus.
  logic unused_offs;
  assign unused_offs = ^{s_axi_awaddr[OFFS-1:0], s_axi_araddr[OFFS-1:0]};

  generate
    if (ADDR_WIDTH > IDX_TOP) begin : g_range
      assign aw_oor = |s_axi_awaddr[ADDR_WIDTH-1:IDX_TOP];
      assign ar_oor = |s_axi_araddr[ADDR_WIDTH-1:IDX_TOP];
    end else begin : g_full
      assign aw_oor = 1'b0;
      assign ar_oor = 1'b0;
    end
  endgenerate

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid  && s_axi_wready;
  assign b_hs   = s_axi_bvalid  && s_axi_bready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign r_hs   = s_axi_rvalid  && s_axi_rready;
  assign commit = (wr_state == WR_IDLE) && aw_held && w_held;
  assign ram_we = commit && !aw_oor_q;

  // ---------------- write channel ----------------
  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      wr_state <= WR_IDLE;
    end else begin
      wr_state <= wr_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (commit) wr_next = WR_RESP;
      WR_RESP: if (b_hs)   wr_next = WR_IDLE;
      default:             wr_next = WR_IDLE;
    endcase
  end

  // Readies stay low for the first cycle after reset so that every output reads 0
  // while reset is asserted.
  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      ready_en <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      aw_oor_q <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= s_axi_awaddr[IDX_TOP-1:OFFS];
        aw_oor_q <= aw_oor;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (commit) begin
        bresp_q <= aw_oor_q ? RESP_SLVERR : RESP_OKAY;
      end
      if (b_hs) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  always_comb begin
    s_axi_awready = ready_en && (wr_state == WR_IDLE) && !aw_held;
    s_axi_wready  = ready_en && (wr_state == WR_IDLE) && !w_held;
    s_axi_bvalid  = (wr_state == WR_RESP);
    s_axi_bresp   = s_axi_bvalid ? bresp_q : RESP_OKAY;
  end

  // ---------------- read channel ----------------
  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      rd_state <= RD_IDLE;
    end else begin
      rd_state <= rd_next;
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_DATA;
      RD_DATA: if (r_hs)  rd_next = RD_IDLE;
      default:            rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      rd_err_q <= 1'b0;
    end else if (ar_hs) begin
      rd_err_q <= ar_oor;
    end
  end

  // The RAM output register only loads on an AR handshake, so rdata holds while
  // RD_DATA waits for rready.
  always_comb begin
    s_axi_arready = ready_en && (rd_state == RD_IDLE);
    s_axi_rvalid  = (rd_state == RD_DATA);
    s_axi_rresp   = (s_axi_rvalid && rd_err_q) ? RESP_SLVERR : RESP_OKAY;
    s_axi_rdata   = (s_axi_rvalid && !rd_err_q) ? ram_q : '0;
  end

  assign dbg_fsm = '{wr: wr_state, rd: rd_state};

  bram_be_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (s_aclk),
    .we    (ram_we),
    .waddr (aw_idx_q),
    .wdata (w_data_q),
    .wbe   (w_strb_q),
    .re    (ar_hs),
    .raddr (s_axi_araddr[IDX_TOP-1:OFFS]),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_axi_lite_bram_strb.sv
// Bench for axi_lite_bram_strb: directed vector table, multi-cycle corner sequences,
// then random traffic checked against a word-array reference model.
module tb_axi_lite_bram_strb;
  import axi_lite_pkg::*;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int NB    = DW / 8;
  localparam int WIN   = 32;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rstn;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic [NB-1:0] wstrb;
  logic [1:0]    bresp, rresp;
  fsm_dbg_t      dbg_fsm;

  always #5 clk = ~clk;

  axi_lite_bram_strb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .s_aclk        (clk),
    .s_aresetn     (rstn),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_awaddr  (awaddr),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_bresp   (bresp),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_araddr  (araddr),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .dbg_fsm       (dbg_fsm)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [int];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [NB-1:0] strb);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) if (strb[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  function automatic bit in_range(input logic [AW-1:0] a);
    return (int'(a) / NB) < DEPTH;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [NB-1:0] strb, input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output int lat);
    bit aw_done, w_done, aw_hs, w_hs, early_b, got_b;
    int c;
    aw_done = 0; w_done = 0; early_b = 0; got_b = 0; c = 0;
    resp = 2'b11; lat = 0;
    while (!(aw_done && w_done) && c < 50) begin
      @(negedge clk);
      awvalid = !aw_done && (c >= aw_dly);
      awaddr  = addr;
      wvalid  = !w_done && (c >= w_dly);
      wdata   = data;
      wstrb   = strb;
      #1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      if (bvalid) early_b = 1;
      @(posedge clk);
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      c++;
    end
    check("wr_handshakes", {aw_done, w_done}, 2'b11);
    check("wr_no_early_bvalid", early_b, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      awvalid = 0;
      wvalid  = 0;
      if (bvalid) begin
        got_b = 1;
        break;
      end
      lat++;
    end
    if (got_b) begin
      resp   = bresp;
      bready = 1;
      @(posedge clk);
      @(negedge clk);
      bready = 0;
      check("wr_bvalid_drop", bvalid, 1'b0);
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp, output int lat);
    bit ar_hs, got_r;
    ar_hs = 0; got_r = 0; data = '1; resp = 2'b11; lat = 0;
    for (int c = 0; c < 50 && !ar_hs; c++) begin
      @(negedge clk);
      arvalid = 1;
      araddr  = addr;
      #1;
      ar_hs = arready;
      @(posedge clk);
    end
    check("rd_handshake", ar_hs, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      arvalid = 0;
      if (rvalid) begin
        got_r = 1;
        break;
      end
      lat++;
    end
    if (got_r) begin
      data   = rdata;
      resp   = rresp;
      rready = 1;
      @(posedge clk);
      @(negedge clk);
      rready = 0;
      check("rd_rvalid_drop", rvalid, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_readies"}, {awready, wready, arready}, 3'b000);
    check({tag, "_valids"},  {bvalid, rvalid}, 2'b00);
    check({tag, "_resps"},   {bresp, rresp}, 4'b0000);
    check({tag, "_rdata"},   rdata, '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            do_wr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [NB-1:0] wstrb;
    int            aw_dly;
    int            w_dly;
    logic [1:0]    exp_bresp;
    logic [AW-1:0] raddr;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_rresp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [1:0]    resp;
    logic [DW-1:0] rd;
    int            lat;

    vecs[0]  = '{1, 16'h0004, 32'h0000000A, 4'hF, 0, 0, RESP_OKAY,   16'h0004, 32'h0000000A, RESP_OKAY};
    vecs[1]  = '{1, 16'h0A0C, 32'h110A0FB9, 4'hF, 2, 0, RESP_OKAY,   16'h0A0C, 32'h110A0FB9, RESP_OKAY};
    vecs[2]  = '{1, 16'h0010, 32'hFFFFFFFF, 4'hF, 0, 0, RESP_OKAY,   16'h0010, 32'hFFFFFFFF, RESP_OKAY};
    vecs[3]  = '{1, 16'h0010, 32'h12345678, 4'h5, 0, 0, RESP_OKAY,   16'h0010, 32'hFF34FF78, RESP_OKAY};
    vecs[4]  = '{1, 16'h0000, 32'h55AA55AA, 4'hF, 0, 0, RESP_OKAY,   16'h0000, 32'h55AA55AA, RESP_OKAY};
    vecs[5]  = '{1, 16'h1000, 32'hDEADBEEF, 4'hF, 0, 0, RESP_SLVERR, 16'h1000, 32'h00000000, RESP_SLVERR};
    vecs[6]  = '{0, 16'h0000, 32'h00000000, 4'h0, 0, 0, RESP_OKAY,   16'h0000, 32'h55AA55AA, RESP_OKAY};
    vecs[7]  = '{1, 16'h0010, 32'h00000000, 4'h0, 0, 0, RESP_OKAY,   16'h0010, 32'hFF34FF78, RESP_OKAY};
    vecs[8]  = '{1, 16'h0020, 32'hCAFEF00D, 4'hF, 0, 3, RESP_OKAY,   16'h0020, 32'hCAFEF00D, RESP_OKAY};
    vecs[9]  = '{1, 16'h0020, 32'h11223344, 4'hA, 0, 0, RESP_OKAY,   16'h0020, 32'h11FE330D, RESP_OKAY};
    vecs[10] = '{1, 16'h0FFC, 32'h0BADF00D, 4'hF, 1, 1, RESP_OKAY,   16'h0FFF, 32'h0BADF00D, RESP_OKAY};
    vecs[11] = '{1, 16'h0FFE, 32'h00C0FFEE, 4'h4, 0, 0, RESP_OKAY,   16'h0FFC, 32'h0BC0F00D, RESP_OKAY};

    rstn = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check("reset_fsm", dbg_fsm, {WR_IDLE, RD_IDLE});
    rstn = 1;

    foreach (vecs[i]) begin
      if (vecs[i].do_wr) begin
        axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, vecs[i].aw_dly, vecs[i].w_dly, resp, lat);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_bresp);
        check($sformatf("vec%0d_b_latency", i), lat, 1);
      end
      axi_read(vecs[i].raddr, rd, resp, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_rresp);
      check($sformatf("vec%0d_r_latency", i), lat, 0);
    end

    // Backpressure: valids stay asserted with changed payloads while responses stall.
    @(negedge clk);
    awvalid = 1; awaddr = 16'h0030; wvalid = 1; wdata = 32'h13579BDF; wstrb = 4'hF;
    arvalid = 1; araddr = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    wdata = 32'hFFFF0000; araddr = 16'h0020;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valids", {bvalid, rvalid}, 2'b11);
      check("bp_resps", {bresp, rresp}, 4'b0000);
      check("bp_rdata", rdata, 32'hFF34FF78);
      check("bp_readies", {awready, wready, arready}, 3'b000);
      @(posedge clk);
    end
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0; rready = 0;
    check("bp_release", {bvalid, rvalid}, 2'b00);
    axi_read(16'h0030, rd, resp, lat);
    check("bp_readback", rd, 32'h13579BDF);

    // Read-first: write commit and AR handshake to the same word on one edge.
    @(negedge clk);
    awvalid = 1; awaddr = 16'h0010; wvalid = 1; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 1; araddr = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    arvalid = 0;
    check("rf_valids", {bvalid, rvalid}, 2'b11);
    check("rf_old_data", rdata, 32'hFF34FF78);
    bready = 1; rready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0; rready = 0;
    axi_read(16'h0010, rd, resp, lat);
    check("rf_new_data", rd, 32'hA5A5A5A5);

    // Reset after AW but before W abandons the write.
    @(negedge clk);
    awvalid = 1; awaddr = 16'h0020;
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; rstn = 0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    wvalid = 1; wdata = 32'h0; wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    wvalid = 0; rstn = 1;
    axi_read(16'h0020, rd, resp, lat);
    check("midrst_old_data", rd, 32'h11FE330D);

    // Random traffic against the reference model.
    for (int w = 0; w < WIN; w++) begin
      logic [DW-1:0] d;
      d = $urandom;
      axi_write(AW'(w * NB), d, 4'hF, 0, 0, resp, lat);
      ref_mem[w] = d;
    end
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [NB-1:0] s;
      int            sel;
      sel = $urandom_range(0, 9);
      if (sel < 7) a = AW'($urandom_range(0, WIN - 1) * NB + $urandom_range(0, NB - 1));
      else if (sel < 9) a = AW'(($urandom_range(1, 15) * DEPTH + $urandom_range(0, WIN - 1)) * NB);
      else a = AW'($urandom_range(16'h1000, 16'hFFFF));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = NB'($urandom);
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp, lat);
        check("rnd_bresp", resp, in_range(a) ? RESP_OKAY : RESP_SLVERR);
        check("rnd_b_latency", lat, 1);
        if (in_range(a)) ref_mem[int'(a) / NB] = merge(ref_mem[int'(a) / NB], d, s);
      end else begin
        exp_q.push_back(in_range(a) ? ref_mem[int'(a) / NB] : '0);
        axi_read(a, rd, resp, lat);
        check("rnd_rdata", rd, exp_q.pop_front());
        check("rnd_rresp", resp, in_range(a) ? RESP_OKAY : RESP_SLVERR);
        check("rnd_r_latency", lat, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
